// File: rtl/fft_frame_buf_ctrl.sv
// Frame-RAM sequencer: captures one FFT frame from a valid/ready stream, then streams it back out.
// Optional build macro FFT_BITREV_EN: write address is the bit-reverse of the beat index.
module fft_frame_buf_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 2048
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_last,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_frame_err,
  output logic              o_ram_wr_en,
  output logic [ADDR_W-1:0] o_ram_wr_addr,
  output logic [DATA_W-1:0] o_ram_wr_data,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [DATA_W-1:0] i_ram_rd_data
);
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READOUT} state_t;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  state_t                   r_state, w_next;
  logic [ADDR_W-1:0]        r_wr_cnt, r_rd_cnt;
  logic                     r_rd_all, r_inflight, r_inflight_last;
  logic                     r_done, r_frame_err;
  logic [1:0][DATA_W-1:0]   r_fifo_data;
  logic [1:0]               r_fifo_last;
  logic                     r_wp, r_rp;
  logic [1:0]               r_occ;
  logic                     w_start_ok, w_s_fire, w_wr_last, w_pop, w_fin, w_rd_issue;
  logic [1:0]               w_occ_after_pop;

  function automatic logic [ADDR_W-1:0] f_map(input logic [ADDR_W-1:0] k);
`ifdef FFT_BITREV_EN
    for (int i = 0; i < ADDR_W; i++) f_map[i] = k[ADDR_W-1-i];
`else
    f_map = k;
`endif
  endfunction

  assign o_s_ready       = (r_state == S_CAPTURE);
  assign o_busy          = (r_state != S_IDLE);
  assign w_s_fire        = i_s_valid & o_s_ready;
  assign w_wr_last       = (r_wr_cnt == LAST_IDX);
  assign w_start_ok      = i_start & ~r_done;
  assign o_m_valid       = (r_occ != 2'd0);
  assign o_m_data        = r_fifo_data[r_rp];
  assign o_m_last        = r_fifo_last[r_rp];
  assign w_pop           = o_m_valid & i_m_ready;
  assign w_fin           = w_pop & o_m_last;
  // Crediting the same-cycle pop keeps the read pipe full at one beat per clock.
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};
  assign w_rd_issue      = (r_state == S_READOUT) && !r_rd_all &&
                           ((w_occ_after_pop + {1'b0, r_inflight}) < 2'd2);

  assign o_ram_wr_en   = w_s_fire;
  assign o_ram_wr_addr = w_s_fire ? f_map(r_wr_cnt) : '0;
  assign o_ram_wr_data = w_s_fire ? i_s_data : '0;
  assign o_ram_rd_addr = r_rd_cnt;
  assign o_done        = r_done;
  assign o_frame_err   = r_frame_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_next = S_CAPTURE;
      S_CAPTURE: if (w_s_fire && w_wr_last) w_next = S_READOUT;
      S_READOUT: if (w_fin) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_cnt        <= '0;
      r_rd_cnt        <= '0;
      r_rd_all        <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
      r_frame_err     <= 1'b0;
      r_fifo_data     <= '0;
      r_fifo_last     <= '0;
      r_wp            <= 1'b0;
      r_rp            <= 1'b0;
      r_occ           <= '0;
    end else begin
      r_done          <= w_fin;
      r_frame_err     <= w_s_fire & (i_s_last ^ w_wr_last);
      r_inflight      <= w_rd_issue;
      r_inflight_last <= w_rd_issue & (r_rd_cnt == LAST_IDX);
      if (r_state == S_IDLE && w_start_ok) begin
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
        r_rd_all <= 1'b0;
      end
      if (w_s_fire && !w_wr_last) r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
      if (w_rd_issue) begin
        if (r_rd_cnt == LAST_IDX) r_rd_all <= 1'b1;
        else                      r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
      end
      if (r_inflight) begin
        r_fifo_data[r_wp] <= i_ram_rd_data;
        r_fifo_last[r_wp] <= r_inflight_last;
        r_wp              <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_fft_frame_buf_ctrl.sv
// Bench for fft_frame_buf_ctrl: behavioural 1-cycle-latency RAM plus a queue of expected output beats.
module tb_fft_frame_buf_ctrl;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int N      = 2048;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic s_ready, m_valid, m_last, busy, done, frame_err, ram_wr_en;
  logic [DATA_W-1:0] m_data, ram_wr_data, ram_rd_data;
  logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;

  logic [DATA_W-1:0] ram   [0:N-1];
  logic [DATA_W-1:0] model [0:N-1];
  logic [DATA_W-1:0] exp_q [$];
  int n_cmp = 0, n_bad = 0;

  fft_frame_buf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data), .i_s_last(s_last),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_m_last(m_last),
    .o_busy(busy), .o_done(done), .o_frame_err(frame_err),
    .o_ram_wr_en(ram_wr_en), .o_ram_wr_addr(ram_wr_addr), .o_ram_wr_data(ram_wr_data),
    .o_ram_rd_addr(ram_rd_addr), .i_ram_rd_data(ram_rd_data));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_rd_addr];
  end

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] k);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = k[ADDR_W-1-i];
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] tb_map(input int k);
`ifdef FFT_BITREV_EN
    return bitrev(ADDR_W'(k));
`else
    return ADDR_W'(k);
`endif
  endfunction

  function automatic logic [DATA_W-1:0] gen(input int dmode, input int beat);
    if (dmode == 0) return DATA_W'(beat);
    if (dmode == 1) return DATA_W'(bitrev(ADDR_W'(beat)));
    return $urandom;
  endfunction

  // dmode: 0 ramp, 1 bit-reversed ramp, 2 random; rmode: 0 always ready, 1 one-in-three, 2 random (with input gaps)
  task automatic run_frame(input int dmode, input int rmode, input int emode, input int mid_start,
                           input int rst_at, input int done_start, input int ext_q,
                           output int n_out, output int n_ferr, output int n_done, output int first_v);
    int beat, cyc;
    logic prev_v, prev_r;
    logic [DATA_W-1:0] prev_d, exp_d;
    n_out = 0; n_ferr = 0; n_done = 0; first_v = -1;
    if (ext_q == 0) exp_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    beat = 0; cyc = 0;
    while (beat < N && cyc < 20000) begin
      s_valid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = gen(dmode, beat);
      s_last  = (emode != 0) ? (beat == 1000) : (beat == N-1);
      start   = (mid_start != 0) && (beat == 100);
      #1;
      if (frame_err) n_ferr++;
      n_cmp++;
      if (s_ready !== 1'b1 || ram_wr_en !== s_valid ||
          (s_valid && (ram_wr_addr !== tb_map(beat) || ram_wr_data !== s_data))) begin
        n_bad++;
        $display("FAIL capture beat=%0d got rdy=%b we=%b addr=%0d data=%h exp rdy=1 we=%b addr=%0d data=%h",
                 beat, s_ready, ram_wr_en, ram_wr_addr, ram_wr_data, s_valid, tb_map(beat), s_data);
      end
      if (s_valid && s_ready) begin
        model[tb_map(beat)] = s_data;
        beat++;
      end
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    if (beat < N) begin
      n_bad++;
      $display("FAIL capture_timeout got beats=%0d exp=%0d", beat, N);
    end
    if (ext_q == 0) for (int k = 0; k < N; k++) exp_q.push_back(model[k]);
    cyc = 0; prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    while (n_out < N && cyc < 10000) begin
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
      if (rst_at >= 0 && n_out == rst_at) break;
      #1;
      if (frame_err) n_ferr++;
      if (done) n_done++;
      if (m_valid && first_v < 0) first_v = cyc;
      if (prev_v && !prev_r) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== prev_d) begin
          n_bad++;
          $display("FAIL stall_hold beat=%0d got v=%b d=%h exp v=1 d=%h", n_out, m_valid, m_data, prev_d);
        end
      end
      if (m_valid && m_ready) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (m_data !== exp_d || m_last !== (n_out == N-1)) begin
          n_bad++;
          $display("FAIL out_beat idx=%0d got d=%h last=%b exp d=%h last=%b",
                   n_out, m_data, m_last, exp_d, (n_out == N-1));
        end
        n_out++;
      end
      prev_v = m_valid; prev_r = m_ready; prev_d = m_data;
      cyc++;
      @(negedge clk);
    end
    if (rst_at < 0) begin
      start = (done_start != 0);
      #1;
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL done_cycle got done=%b busy=%b mv=%b exp done=1 busy=0 mv=0", done, busy, m_valid);
      end
      if (done) n_done++;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); start = 1'b0; #1;
        n_cmp++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL post_idle cyc=%0d got busy=%b rdy=%b done=%b exp 0/0/0", i, busy, s_ready, done);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({s_ready, m_valid, m_last, busy, done, frame_err, ram_wr_en} !== 7'b0 ||
        ram_wr_addr !== '0 || ram_wr_data !== '0 || ram_rd_addr !== '0 || m_data !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b mv=%b ml=%b busy=%b done=%b fe=%b we=%b wa=%0d wd=%h ra=%0d md=%h exp all 0",
               s_ready, m_valid, m_last, busy, done, frame_err, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, m_data);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset got busy=%b rdy=%b exp 0/0", busy, s_ready);
    end
  endtask

  task automatic check_frame(input string name, input int n_out, input int n_ferr, input int n_done,
                             input int exp_ferr);
    n_cmp++;
    if (n_out != N || n_ferr != exp_ferr || n_done != 1) begin
      n_bad++;
      $display("FAIL %s got beats=%0d ferr=%0d done=%0d exp beats=%0d ferr=%0d done=1",
               name, n_out, n_ferr, n_done, N, exp_ferr);
    end
  endtask

  task automatic test_basic();
    int n_out, n_ferr, n_done, first_v;
    run_frame(0, 0, 0, 0, -1, 0, 0, n_out, n_ferr, n_done, first_v);
    check_frame("basic_frame", n_out, n_ferr, n_done, 0);
    n_cmp++;
    if (first_v != 2) begin
      n_bad++;
      $display("FAIL first_valid_latency got %0d exp 2", first_v);
    end
  endtask

  task automatic test_backpressure();
    int n_out, n_ferr, n_done, first_v;
    run_frame(0, 1, 0, 0, -1, 0, 0, n_out, n_ferr, n_done, first_v);
    check_frame("bp_one_in_three", n_out, n_ferr, n_done, 0);
    run_frame(2, 2, 0, 0, -1, 0, 0, n_out, n_ferr, n_done, first_v);
    check_frame("bp_random", n_out, n_ferr, n_done, 0);
  endtask

  task automatic test_bitrev();
    int n_out, n_ferr, n_done, first_v;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
`ifdef FFT_BITREV_EN
      exp_q.push_back(DATA_W'(k));
`else
      exp_q.push_back(DATA_W'(bitrev(ADDR_W'(k))));
`endif
    end
    run_frame(1, 0, 0, 0, -1, 0, 1, n_out, n_ferr, n_done, first_v);
    check_frame("bitrev_frame", n_out, n_ferr, n_done, 0);
  endtask

  task automatic test_frame_err();
    int n_out, n_ferr, n_done, first_v;
    run_frame(0, 0, 1, 0, -1, 0, 0, n_out, n_ferr, n_done, first_v);
    check_frame("frame_err_frame", n_out, n_ferr, n_done, 2);
  endtask

  task automatic test_rst_mid();
    int n_out, n_ferr, n_done, first_v;
    run_frame(0, 0, 0, 0, 500, 0, 0, n_out, n_ferr, n_done, first_v);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || n_out != 500) begin
      n_bad++;
      $display("FAIL rst_mid got mv=%b busy=%b done=%b beats=%0d exp 0/0/0 beats=500", m_valid, busy, done, n_out);
    end
    rst = 1'b0;
    run_frame(2, 0, 0, 0, -1, 0, 0, n_out, n_ferr, n_done, first_v);
    check_frame("after_rst_frame", n_out, n_ferr, n_done, 0);
  endtask

  task automatic test_start_ignored();
    int n_out, n_ferr, n_done, first_v;
    run_frame(0, 1, 0, 1, -1, 1, 0, n_out, n_ferr, n_done, first_v);
    check_frame("start_ignored_frame", n_out, n_ferr, n_done, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bitrev();
    test_frame_err();
    test_rst_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
